normalizer_dma_arbiter: RTL and testbench

Round-robin arbiter sharing the single client port of `normalizer_dma` among `N_REQ` requesters, typically the normalizer datapath stages and the control CPU. It accepts level-held read/write requests and forwards one transaction at a time as a single-cycle command pulse. It returns the completion pulse and read data only to the granted requester. A watchdog reports a downstream stall to the requester.

---
 rtl/normalizer_pkg.sv | 15 +
 rtl/normalizer_dma_arbiter_rr_pick.sv | 30 +++
 rtl/normalizer_dma_arbiter.sv | 138 +++++++++++++
 tb/tb_normalizer_dma_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/normalizer_pkg.sv
// Shared types and constants for the normalizer DMA client-side logic.
package normalizer_pkg;

    localparam int unsigned DMA_DW              = 32;
    localparam int unsigned ARB_TIMEOUT_DEFAULT = 1023;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE,
        ARB_FLUSH
    } arb_state_t;

endpackage

// File: rtl/normalizer_dma_arbiter_rr_pick.sv
// Combinational round-robin pick: first pending index after last_i, wrapping.
module rr_pick #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pend_i,
    input  logic [IW-1:0]    last_i,
    output logic             valid_o,
    output logic [IW-1:0]    idx_o
);

    int unsigned       cand;
    logic [IW-1:0]     cand_idx;

    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand     = (32'(last_i) + i) % N_REQ;
            cand_idx = IW'(cand);
            if (!valid_o && pend_i[cand_idx]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/normalizer_dma_arbiter.sv
// Round-robin arbiter multiplexing N_REQ requesters onto the single normalizer_dma client port,
// with a watchdog that reports a stalled downstream and drains its late completion.
module normalizer_dma_arbiter
    import normalizer_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DMA_DW*N_REQ-1:0] req_addr,
    input  logic [N_REQ-1:0]        req_read,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [DMA_DW*N_REQ-1:0] req_writedata,
    output logic [DMA_DW-1:0]       req_readdata,
    output logic [N_REQ-1:0]        req_rdy,
    output logic                    req_err,
    output logic [DMA_DW-1:0]       dma_addr,
    output logic [DMA_DW-1:0]       dma_writedata,
    output logic                    dma_read,
    output logic                    dma_write,
    input  logic [DMA_DW-1:0]       dma_readdata,
    input  logic                    dma_rdy
);

    localparam int unsigned   IW       = $clog2(N_REQ);
    localparam logic [15:0]   CNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

    arb_state_t        state_q;
    logic [IW-1:0]     grant_q;
    logic [IW-1:0]     last_q;
    logic              is_wr_q;
    logic              err_q;
    logic [DMA_DW-1:0] addr_q;
    logic [DMA_DW-1:0] wdata_q;
    logic [DMA_DW-1:0] rdata_q;
    logic [15:0]       cnt_q;

    logic [N_REQ-1:0]  pend;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [DMA_DW-1:0] addr_arr  [N_REQ];
    logic [DMA_DW-1:0] wdata_arr [N_REQ];

    assign pend = req_read | req_write;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign addr_arr[g]  = req_addr[g*DMA_DW +: DMA_DW];
        assign wdata_arr[g] = req_writedata[g*DMA_DW +: DMA_DW];
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .pend_i  (pend),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_idx;
                        addr_q  <= addr_arr[pick_idx];
                        // write wins when both request bits are high; reads carry zero data
                        is_wr_q <= req_write[pick_idx];
                        wdata_q <= req_write[pick_idx] ? wdata_arr[pick_idx] : '0;
                        state_q <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (dma_rdy) begin
                        rdata_q <= is_wr_q ? '0 : dma_readdata;
                        err_q   <= 1'b0;
                        state_q <= ARB_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= ARB_DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ARB_DONE: begin
                    last_q  <= grant_q;
                    state_q <= err_q ? ARB_FLUSH : ARB_IDLE;
                end
                ARB_FLUSH: begin
                    // the timed-out command is still owed a dma_rdy; swallow it before re-arbitrating
                    if (dma_rdy) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        dma_read      = 1'b0;
        dma_write     = 1'b0;
        dma_addr      = '0;
        dma_writedata = '0;
        req_rdy       = '0;
        req_readdata  = '0;
        req_err       = 1'b0;
        if (state_q == ARB_ISSUE) begin
            dma_read      = ~is_wr_q;
            dma_write     = is_wr_q;
            dma_addr      = addr_q;
            dma_writedata = wdata_q;
        end
        if (state_q == ARB_DONE) begin
            req_rdy[grant_q] = 1'b1;
            req_readdata     = rdata_q;
            req_err          = err_q;
        end
    end

endmodule

// File: tb/tb_normalizer_dma_arbiter.sv
// Scoreboard bench: expected commands/completions are queued as stimulus is driven, popped when the DUT emits them.
module tb_normalizer_dma_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [32*N-1:0]   req_addr;
    logic [32*N-1:0]   req_writedata;
    logic [N-1:0]      req_read;
    logic [N-1:0]      req_write;
    logic [N-1:0]      req_rdy;
    logic [31:0]       req_readdata;
    logic              req_err;
    logic [31:0]       dma_addr;
    logic [31:0]       dma_writedata;
    logic              dma_read;
    logic              dma_write;
    logic [31:0]       dma_readdata = '0;
    logic              dma_rdy = 1'b0;

    always #5 clk = ~clk;

    normalizer_dma_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_addr      (req_addr),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_writedata (req_writedata),
        .req_readdata  (req_readdata),
        .req_rdy       (req_rdy),
        .req_err       (req_err),
        .dma_addr      (dma_addr),
        .dma_writedata (dma_writedata),
        .dma_read      (dma_read),
        .dma_write     (dma_write),
        .dma_readdata  (dma_readdata),
        .dma_rdy       (dma_rdy)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        int unsigned at;
    } cmd_t;

    typedef struct {
        logic [N-1:0] rdy;
        logic [31:0]  data;
        logic         err;
        int unsigned  at;
    } cpl_t;

    cmd_t cmd_q[$];
    cpl_t cpl_q[$];
    cmd_t mc;
    cpl_t mp;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return 32'hDEADBEEF ^ (a - 32'h100);
    endfunction

    // Downstream stand-in for normalizer_dma: answers each command resp_delay cycles after it.
    int          resp_delay = 2;
    bit          resp_stall = 1'b0;
    int          resp_cnt   = -1;
    logic        resp_isrd  = 1'b0;
    logic [31:0] resp_addr  = '0;
    int          inject_n   = 0;
    int          inject_seen = 0;

    always @(negedge clk) begin
        dma_rdy      = 1'b0;
        dma_readdata = '0;
        if (!rst) begin
            resp_cnt = -1;
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    dma_rdy      = 1'b1;
                    dma_readdata = resp_isrd ? model_rd(resp_addr) : 32'hFFFF_FFFF;
                    resp_cnt     = -1;
                end
            end
            if (inject_n != inject_seen) begin
                inject_seen++;
                dma_rdy      = 1'b1;
                dma_readdata = 32'hBAD0_BAD0;
            end
            if (dma_read || dma_write) begin
                resp_isrd = dma_read;
                resp_addr = dma_addr;
                resp_cnt  = resp_stall ? -1 : resp_delay;
            end
        end
    end

    // Output monitor: pops the scoreboard on every command / completion and checks quiet outputs otherwise.
    always @(negedge clk) begin
        if (rst) begin
            if (dma_read || dma_write) begin
                check_val("cmd_expected", 64'(cmd_q.size() != 0), 64'd1);
                if (cmd_q.size() != 0) begin
                    mc = cmd_q.pop_front();
                    check_val("cmd_read", 64'(dma_read), 64'(mc.rd));
                    check_val("cmd_write", 64'(dma_write), 64'(mc.wr));
                    check_val("cmd_addr", 64'(dma_addr), 64'(mc.addr));
                    check_val("cmd_wdata", 64'(dma_writedata), 64'(mc.wd));
                    check_val("cmd_cycle", 64'(cyc), 64'(mc.at));
                end
            end else begin
                check_val("dma_quiet", {dma_addr, dma_writedata}, 64'd0);
            end
            if (req_rdy != '0) begin
                check_val("cpl_expected", 64'(cpl_q.size() != 0), 64'd1);
                if (cpl_q.size() != 0) begin
                    mp = cpl_q.pop_front();
                    check_val("cpl_rdy", 64'(req_rdy), 64'(mp.rdy));
                    check_val("cpl_data", 64'(req_readdata), 64'(mp.data));
                    check_val("cpl_err", 64'(req_err), 64'(mp.err));
                    check_val("cpl_cycle", 64'(cyc), 64'(mp.at));
                end
            end else begin
                check_val("req_quiet", 64'({req_err, req_readdata}), 64'd0);
            end
        end
    end

    task automatic set_req(input int unsigned i, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd);
        req_read[i]             = rd;
        req_write[i]            = wr;
        req_addr[i*32 +: 32]      = a;
        req_writedata[i*32 +: 32] = wd;
    endtask

    task automatic push_cmd(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int unsigned at);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = a; c.wd = wd; c.at = at;
        cmd_q.push_back(c);
    endtask

    task automatic push_cpl(input logic [N-1:0] rdy, input logic [31:0] d,
                            input logic e, input int unsigned at);
        cpl_t p;
        p.rdy = rdy; p.data = d; p.err = e; p.at = at;
        cpl_q.push_back(p);
    endtask

    task automatic wait_cpls(input int unsigned n, input int unsigned budget, input bit drop);
        int unsigned got = 0;
        for (int unsigned t = 0; t < budget && got < n; t++) begin
            @(negedge clk);
            if (req_rdy != '0) begin
                got++;
                if (drop) begin
                    req_read  = req_read & ~req_rdy;
                    req_write = req_write & ~req_rdy;
                end
            end
        end
        check_val("cpl_count", 64'(got), 64'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_cmd"}, 64'({dma_read, dma_write}), 64'd0);
        check_val({tag, "_dma_addr"}, 64'(dma_addr), 64'd0);
        check_val({tag, "_dma_wd"}, 64'(dma_writedata), 64'd0);
        check_val({tag, "_rdy"}, 64'(req_rdy), 64'd0);
        check_val({tag, "_rdata"}, 64'(req_readdata), 64'd0);
        check_val({tag, "_err"}, 64'(req_err), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench did not reach its end");
    end

    initial begin
        int unsigned t0;
        int unsigned jc;
        logic [31:0] a;

        rst = 1'b0;
        req_read = '0; req_write = '0; req_addr = '0; req_writedata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // single read from requester 2, downstream answers in cycle 3
        @(negedge clk);
        resp_delay = 2;
        t0 = cyc;
        set_req(2, 1'b1, 1'b0, 32'h100, 32'h1111_2222);
        push_cmd(1'b1, 1'b0, 32'h100, 32'h0, t0 + 1);
        push_cpl(4'b0100, 32'hDEADBEEF, 1'b0, t0 + 4);
        wait_cpls(1, 20, 1'b1);
        repeat (2) @(negedge clk);

        // read and write both high: write wins, completion carries no data
        t0 = cyc;
        set_req(0, 1'b1, 1'b1, 32'h200, 32'h5A5A);
        push_cmd(1'b0, 1'b1, 32'h200, 32'h5A5A, t0 + 1);
        push_cpl(4'b0001, 32'h0, 1'b0, t0 + 4);
        wait_cpls(1, 20, 1'b1);
        repeat (2) @(negedge clk);

        // watchdog: no dma_rdy, requester 1 must wait for the late completion to drain
        resp_stall = 1'b1;
        t0 = cyc;
        set_req(0, 1'b1, 1'b0, 32'h300, 32'h0);
        push_cmd(1'b1, 1'b0, 32'h300, 32'h0, t0 + 1);
        push_cpl(4'b0001, 32'h0, 1'b1, t0 + 2 + TO);
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 32'h340, 32'h0);
        wait_cpls(1, 30, 1'b1);
        repeat (5) @(negedge clk);
        resp_stall = 1'b0;
        resp_delay = 2;
        @(posedge clk);
        #1;
        jc = cyc;
        push_cmd(1'b1, 1'b0, 32'h340, 32'h0, jc + 2);
        push_cpl(4'b0010, model_rd(32'h340), 1'b0, jc + 5);
        inject_n++;
        wait_cpls(1, 20, 1'b1);
        repeat (2) @(negedge clk);

        // reset while waiting on downstream: abandoned with no completion
        resp_stall = 1'b1;
        t0 = cyc;
        set_req(2, 1'b1, 1'b0, 32'h500, 32'h0);
        push_cmd(1'b1, 1'b0, 32'h500, 32'h0, t0 + 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        req_read = '0;
        @(negedge clk);
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b1;
        resp_stall = 1'b0;
        resp_delay = 1;
        @(negedge clk);

        // all requesters held: priority restarts at 0 and rotates every 4 cycles
        t0 = cyc;
        for (int unsigned i = 0; i < N; i++) begin
            set_req(i, 1'b1, 1'b0, 32'h1000 + 32'(i) * 4, 32'h0);
        end
        for (int unsigned j = 0; j < 5; j++) begin
            a = 32'h1000 + 32'(j % N) * 4;
            push_cmd(1'b1, 1'b0, a, 32'h0, t0 + 1 + 4 * j);
            push_cpl(N'(1 << (j % N)), model_rd(a), 1'b0, t0 + 3 + 4 * j);
        end
        wait_cpls(5, 40, 1'b0);
        req_read = '0;
        repeat (4) @(negedge clk);

        check_val("cmd_q_left", 64'(cmd_q.size()), 64'd0);
        check_val("cpl_q_left", 64'(cpl_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
